// File: rtl/fp_uart_pkg.sv
// Shared UART receive definitions: FSM states, frame geometry and default bit timing.
package fp_uart_pkg;
  localparam int UART_DATA_BITS       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 5208;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_e;
endpackage

// File: rtl/uart_rx_byte_engine.sv
// 8N1 byte receiver: input synchroniser, bit timer and START/DATA/STOP/BREAK state machine.
module uart_rx_byte_engine
  import fp_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic                      idle,
  output logic                      byte_valid,
  output logic                      frame_err,
  output logic [UART_DATA_BITS-1:0] rx_byte
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int BIT_W = $clog2(UART_DATA_BITS + 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(UART_DATA_BITS - 1);

  logic [SYNC_STAGES-1:0]    sync_q;
  logic                      rx_s;
  rx_state_e                 state;
  logic [CNT_W-1:0]          cnt;
  logic [BIT_W-1:0]          bit_cnt;
  logic [UART_DATA_BITS-1:0] shift;

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign idle = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '1;
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], rx};
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          // Mid-start sample: a line already back high was only a glitch.
          if (cnt == HALF_CNT) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL_CNT) begin
            cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == FULL_CNT) begin
            cnt <= '0;
            if (rx_s) begin
              byte_valid <= 1'b1;
              state      <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == DATA && cnt == FULL_CNT) shift <= {rx_s, shift[UART_DATA_BITS-1:1]};
    if (state == STOP && cnt == FULL_CNT && rx_s) rx_byte <= shift;
  end
endmodule

// File: rtl/fp32_uart_rx_word.sv
// UART word receiver: packs NUM_BYTES bytes into one word behind a valid/ready output
// buffer, with framing, overrun and inter-byte timeout reporting.
module fp32_uart_rx_word
  import fp_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int NUM_BYTES    = 12,
  parameter int SYNC_STAGES  = 2,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic                              CLK_I,
  input  logic                              RST_I,
  input  logic                              UART_RX_I,
  input  logic                              RX_READY_I,
  output logic                              RX_VALID_O,
  output logic [UART_DATA_BITS*NUM_BYTES-1:0] RX_DATA_O,
  output logic                              FRAME_ERR_O,
  output logic                              OVERRUN_O,
  output logic                              TIMEOUT_O
);
  localparam int WORD_W    = UART_DATA_BITS * NUM_BYTES;
  localparam int BC_W      = $clog2(NUM_BYTES + 1);
  localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W      = (TO_CYCLES > 0) ? $clog2(TO_CYCLES + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST   = (TO_CYCLES > 0) ? TO_W'(TO_CYCLES - 1) : '0;
  localparam logic [BC_W-1:0] LAST_SLOT = BC_W'(NUM_BYTES - 1);

  logic                      eng_idle;
  logic                      byte_valid;
  logic                      frame_err;
  logic [UART_DATA_BITS-1:0] rx_byte;
  logic [BC_W-1:0]           byte_cnt;
  logic [TO_W-1:0]           to_cnt;
  logic [WORD_W-1:0]         assembly;
  logic [WORD_W-1:0]         next_word;
  logic                      word_done;

  uart_rx_byte_engine #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_engine (
    .clk       (CLK_I),
    .rst       (RST_I),
    .rx        (UART_RX_I),
    .idle      (eng_idle),
    .byte_valid(byte_valid),
    .frame_err (frame_err),
    .rx_byte   (rx_byte)
  );

  assign FRAME_ERR_O = frame_err;
  assign word_done   = byte_valid && (byte_cnt == LAST_SLOT);

  // Assembly including the byte arriving this cycle, so a completing word is whole.
  always_comb begin
    next_word = assembly;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (byte_cnt == BC_W'(k)) next_word[UART_DATA_BITS*k +: UART_DATA_BITS] = rx_byte;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (byte_valid) assembly <= next_word;
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      byte_cnt  <= '0;
      to_cnt    <= '0;
      TIMEOUT_O <= 1'b0;
    end else begin
      TIMEOUT_O <= 1'b0;
      if (frame_err) begin
        byte_cnt <= '0;
        to_cnt   <= '0;
      end else if (byte_valid) begin
        byte_cnt <= word_done ? '0 : byte_cnt + 1'b1;
        to_cnt   <= '0;
      end else if (TIMEOUT_BITS == 0 || !eng_idle || byte_cnt == '0) begin
        to_cnt <= '0;
      end else if (to_cnt == TO_LAST) begin
        TIMEOUT_O <= 1'b1;
        byte_cnt  <= '0;
        to_cnt    <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  // A finished word is taken if the buffer is empty or being drained this same cycle.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      RX_VALID_O <= 1'b0;
      RX_DATA_O  <= '0;
      OVERRUN_O  <= 1'b0;
    end else begin
      OVERRUN_O <= 1'b0;
      if (word_done) begin
        if (!RX_VALID_O || RX_READY_I) begin
          RX_DATA_O  <= next_word;
          RX_VALID_O <= 1'b1;
        end else begin
          OVERRUN_O <= 1'b1;
        end
      end else if (RX_READY_I) begin
        RX_VALID_O <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fp32_uart_rx_word.sv
// Bench for fp32_uart_rx_word: serial stimulus with random bytes, gaps and ready, against a word-level model.
module tb_fp32_uart_rx_word;
  localparam int CPB = 16;
  localparam int NB  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        ready;
  logic        valid;
  logic [31:0] data;
  logic        fe;
  logic        ov;
  logic        to;

  int n_tests = 0;
  int n_fail  = 0;
  int rd_idx  = 0;
  bit rand_done;

  int          n_fe = 0, n_ov = 0, n_to = 0, n_vrise = 0, n_multi = 0, n_unstable = 0;
  logic [31:0] acc_q[$];
  logic        prev_v = 1'b0;
  logic        prev_r = 1'b0;
  logic [31:0] prev_d = '0;

  fp32_uart_rx_word #(
    .CLKS_PER_BIT(CPB),
    .NUM_BYTES   (NB),
    .SYNC_STAGES (2),
    .TIMEOUT_BITS(4)
  ) dut (
    .CLK_I      (clk),
    .RST_I      (rst),
    .UART_RX_I  (rx),
    .RX_READY_I (ready),
    .RX_VALID_O (valid),
    .RX_DATA_O  (data),
    .FRAME_ERR_O(fe),
    .OVERRUN_O  (ov),
    .TIMEOUT_O  (to)
  );

  always #5 clk = ~clk;

  // Observer: counts pulses, records accepted words, watches buffer stability.
  always @(negedge clk) begin
    if (rst) begin
      prev_v <= 1'b0;
      prev_r <= 1'b0;
    end else begin
      if (fe) n_fe <= n_fe + 1;
      if (ov) n_ov <= n_ov + 1;
      if (to) n_to <= n_to + 1;
      if (int'(fe) + int'(ov) + int'(to) > 1) n_multi <= n_multi + 1;
      if (valid && !prev_v) n_vrise <= n_vrise + 1;
      if (valid && ready) acc_q.push_back(data);
      if (prev_v && !prev_r && (!valid || data !== prev_d)) n_unstable <= n_unstable + 1;
      prev_v <= valid;
      prev_r <= ready;
      prev_d <= data;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int gap);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
    if (stop_bit) rx = 1'b1;
    tick(gap);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < NB; k++) send_byte(w[8*k +: 8], 1'b1, gap);
  endtask

  function automatic logic [31:0] model_word(input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2, input logic [7:0] b3);
    return 32'(b0) + 32'(b1) * 32'd256 + 32'(b2) * 32'd65536 + 32'(b3) * 32'd16777216;
  endfunction

  task automatic test_reset;
    rst = 1'b1; rx = 1'b1; ready = 1'b0;
    tick(3);
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
    n_tests++; if (data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 00000000", data); end
    n_tests++; if ({fe, ov, to} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b expected 000", {fe, ov, to}); end
    rst = 1'b0;
    tick(5);
    n_tests++; if (valid !== 1'b0 || data !== 32'h0) begin n_fail++; $display("FAIL reset_release: valid %b data %h expected 0 00000000", valid, data); end
  endtask

  task automatic test_single_word;
    int v0 = n_vrise, e0 = n_fe + n_ov + n_to, a0 = acc_q.size();
    ready = 1'b1;
    send_word(32'h44332211, 2);
    tick(6);
    n_tests++; if (acc_q.size() != a0 + 1) begin n_fail++; $display("FAIL single_count: got %0d words expected 1", acc_q.size() - a0); end
    n_tests++; if (acc_q.size() > a0 && acc_q[a0] !== model_word(8'h11, 8'h22, 8'h33, 8'h44)) begin
      n_fail++; $display("FAIL single_data: got %h expected 44332211", acc_q[a0]); end
    n_tests++; if (n_vrise - v0 != 1) begin n_fail++; $display("FAIL single_vpulse: got %0d expected 1", n_vrise - v0); end
    n_tests++; if (n_fe + n_ov + n_to - e0 != 0) begin n_fail++; $display("FAIL single_errors: got %0d expected 0", n_fe + n_ov + n_to - e0); end
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL single_vdrop: got %b expected 0", valid); end
    rd_idx = acc_q.size();
  endtask

  task automatic test_random_stream;
    logic [7:0]  bytes[20];
    logic [31:0] exp_w[5];
    int o0 = n_ov, u0 = n_unstable, a0 = acc_q.size();
    for (int w = 0; w < 5; w++) begin
      for (int k = 0; k < NB; k++) bytes[w*NB + k] = 8'($urandom);
      exp_w[w] = model_word(bytes[w*NB], bytes[w*NB+1], bytes[w*NB+2], bytes[w*NB+3]);
    end
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) send_byte(bytes[i], 1'b1, int'($urandom_range(0, 30)));
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          ready = 1'($urandom_range(0, 1));
          tick(1);
        end
      end
    join
    ready = 1'b1;
    tick(6);
    n_tests++; if (acc_q.size() != a0 + 5) begin n_fail++; $display("FAIL stream_count: got %0d words expected 5", acc_q.size() - a0); end
    for (int w = 0; w < 5; w++) begin
      if (acc_q.size() > a0 + w) begin
        n_tests++; if (acc_q[a0 + w] !== exp_w[w]) begin n_fail++; $display("FAIL stream_word%0d: got %h expected %h", w, acc_q[a0 + w], exp_w[w]); end
      end
    end
    n_tests++; if (n_ov != o0) begin n_fail++; $display("FAIL stream_overrun: got %0d expected 0", n_ov - o0); end
    n_tests++; if (n_unstable != u0) begin n_fail++; $display("FAIL stream_hold: got %0d changes expected 0", n_unstable - u0); end
    rd_idx = acc_q.size();
  endtask

  task automatic test_overrun;
    logic [31:0] wa = $urandom, wb = $urandom, wc = $urandom;
    int o0 = n_ov, a0 = acc_q.size();
    ready = 1'b0;
    send_word(wa, 2);
    tick(4);
    n_tests++; if (valid !== 1'b1 || data !== wa) begin n_fail++; $display("FAIL ovr_first: valid %b data %h expected 1 %h", valid, data, wa); end
    send_word(wb, 2);
    tick(4);
    n_tests++; if (n_ov - o0 != 1) begin n_fail++; $display("FAIL ovr_pulse: got %0d expected 1", n_ov - o0); end
    n_tests++; if (valid !== 1'b1 || data !== wa) begin n_fail++; $display("FAIL ovr_kept: valid %b data %h expected 1 %h", valid, data, wa); end
    ready = 1'b1;
    tick(1);
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drop: got %b expected 0", valid); end
    send_word(wc, 3);
    tick(6);
    n_tests++; if (acc_q.size() != a0 + 2) begin n_fail++; $display("FAIL ovr_count: got %0d words expected 2", acc_q.size() - a0); end
    if (acc_q.size() >= a0 + 2) begin
      n_tests++; if (acc_q[a0] !== wa) begin n_fail++; $display("FAIL ovr_acc_a: got %h expected %h", acc_q[a0], wa); end
      n_tests++; if (acc_q[a0+1] !== wc) begin n_fail++; $display("FAIL ovr_acc_c: got %h expected %h", acc_q[a0+1], wc); end
    end
    rd_idx = acc_q.size();
  endtask

  task automatic test_frame_err;
    int f0 = n_fe, a0 = acc_q.size();
    ready = 1'b1;
    send_byte(8'($urandom), 1'b1, 2);
    send_byte(8'($urandom), 1'b1, 2);
    send_byte(8'($urandom), 1'b0, 0);
    tick(40);
    rx = 1'b1;
    tick(20);
    n_tests++; if (n_fe - f0 != 1) begin n_fail++; $display("FAIL frame_pulse: got %0d expected 1", n_fe - f0); end
    n_tests++; if (acc_q.size() != a0 || valid !== 1'b0) begin n_fail++; $display("FAIL frame_novalid: words %0d valid %b expected 0 0", acc_q.size() - a0, valid); end
    send_word(32'hDEADBEEF, 1);
    tick(6);
    n_tests++; if (acc_q.size() != a0 + 1 || acc_q[acc_q.size()-1] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL frame_recover: words %0d last %h expected 1 deadbeef", acc_q.size() - a0, acc_q[acc_q.size()-1]); end
    rd_idx = acc_q.size();
  endtask

  task automatic test_timeout;
    for (int r = 0; r < 2; r++) begin
      int t0 = n_to, a0 = acc_q.size();
      int nb = (r == 0) ? 2 : int'($urandom_range(1, 3));
      logic [31:0] held = $urandom;
      logic [31:0] fresh = $urandom;
      if (r == 1) begin
        ready = 1'b0;
        send_word(held, 2);
      end
      for (int k = 0; k < nb; k++) send_byte((r == 0) ? ((k == 0) ? 8'hAA : 8'hBB) : 8'($urandom), 1'b1, 0);
      tick(80);
      n_tests++; if (n_to - t0 != 1) begin n_fail++; $display("FAIL timeout_pulse%0d: got %0d expected 1", r, n_to - t0); end
      if (r == 1) begin
        n_tests++; if (valid !== 1'b1 || data !== held) begin n_fail++; $display("FAIL timeout_keep: valid %b data %h expected 1 %h", valid, data, held); end
        ready = 1'b1;
        tick(2);
      end
      if (r == 0) fresh = 32'h04030201;
      send_word(fresh, 2);
      ready = 1'b1;
      tick(6);
      n_tests++; if (acc_q.size() == 0 || acc_q[acc_q.size()-1] !== fresh || acc_q.size() != a0 + r + 1) begin
        n_fail++; $display("FAIL timeout_next%0d: words %0d last %h expected %0d %h", r, acc_q.size() - a0, acc_q[acc_q.size()-1], r + 1, fresh); end
    end
    rd_idx = acc_q.size();
  endtask

  task automatic test_glitch;
    int e0 = n_fe + n_ov + n_to, v0 = n_vrise, a0 = acc_q.size();
    logic [31:0] w = $urandom;
    ready = 1'b1;
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(40);
    n_tests++; if (n_fe + n_ov + n_to != e0 || n_vrise != v0 || valid !== 1'b0) begin
      n_fail++; $display("FAIL glitch_quiet: pulses %0d vrise %0d valid %b expected 0 0 0", n_fe + n_ov + n_to - e0, n_vrise - v0, valid); end
    send_word(w, 2);
    tick(6);
    n_tests++; if (acc_q.size() != a0 + 1 || acc_q[acc_q.size()-1] !== w) begin
      n_fail++; $display("FAIL glitch_word: words %0d last %h expected 1 %h", acc_q.size() - a0, acc_q[acc_q.size()-1], w); end
    rd_idx = acc_q.size();
  endtask

  task automatic test_reset_mid;
    logic [31:0] w1 = $urandom, w2 = $urandom, w3 = $urandom;
    int a0 = acc_q.size();
    ready = 1'b0;
    send_word(w1, 2);
    send_byte(w2[7:0], 1'b1, 2);
    send_byte(w2[15:8], 1'b1, 2);
    rx = 1'b0;
    tick(CPB);
    rx = w2[16];
    tick(CPB * 2);
    #2;
    rst = 1'b1;
    rx = 1'b1;
    #1;
    n_tests++; if (valid !== 1'b0 || data !== 32'h0) begin n_fail++; $display("FAIL rstmid_outputs: valid %b data %h expected 0 00000000", valid, data); end
    tick(2);
    rst = 1'b0;
    ready = 1'b1;
    tick(4);
    n_tests++; if (valid !== 1'b0 || acc_q.size() != a0) begin n_fail++; $display("FAIL rstmid_cleared: valid %b words %0d expected 0 0", valid, acc_q.size() - a0); end
    send_word(w3, 2);
    tick(6);
    n_tests++; if (acc_q.size() != a0 + 1 || acc_q[acc_q.size()-1] !== w3) begin
      n_fail++; $display("FAIL rstmid_word: words %0d last %h expected 1 %h", acc_q.size() - a0, acc_q[acc_q.size()-1], w3); end
    rd_idx = acc_q.size();
  endtask

  task automatic test_fp32_values;
    logic [31:0] vals[3] = '{32'h3F800000, 32'h40000000, 32'hBF000000};
    int a0 = acc_q.size();
    ready = 1'b1;
    for (int i = 0; i < 3; i++) send_word(vals[i], int'($urandom_range(0, 20)));
    tick(6);
    n_tests++; if (acc_q.size() != a0 + 3) begin n_fail++; $display("FAIL fp32_count: got %0d expected 3", acc_q.size() - a0); end
    for (int i = 0; i < 3; i++) begin
      if (acc_q.size() > a0 + i) begin
        n_tests++; if (acc_q[a0 + i] !== vals[i]) begin n_fail++; $display("FAIL fp32_word%0d: got %h expected %h", i, acc_q[a0 + i], vals[i]); end
      end
    end
    rd_idx = acc_q.size();
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_random_stream();
    test_overrun();
    test_frame_err();
    test_timeout();
    test_glitch();
    test_reset_mid();
    test_fp32_values();
    n_tests++; if (n_multi != 0) begin n_fail++; $display("FAIL pulse_exclusive: got %0d overlapping cycles expected 0", n_multi); end
    n_tests++; if (n_unstable != 0) begin n_fail++; $display("FAIL hold_stable: got %0d changes expected 0", n_unstable); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
